// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/counter generator with built-in test patterns
// Define VGA_SCROLL_EN to scroll modes 0-2 horizontally by one pixel per frame.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PX_DIV    = 4,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int COLOR_W   = 4
) (
  input  logic               clk,
  input  logic               i_sclr_n,
  input  logic [1:0]         i_mode,
  output logic [COLOR_W-1:0] o_vga_red,
  output logic [COLOR_W-1:0] o_vga_green,
  output logic [COLOR_W-1:0] o_vga_blue,
  output logic               o_vga_hsync,
  output logic               o_vga_vsync,
  output logic               o_de,
  output logic               o_frame_start,
  output logic [10:0]        o_x,
  output logic [10:0]        o_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
  localparam logic [3:0]  DIV_LAST = 4'(PX_DIV - 1);
  localparam logic        HS_ON    = 1'(HSYNC_POL);
  localparam logic        VS_ON    = 1'(VSYNC_POL);
  localparam logic [COLOR_W-1:0] FULL = '1;

  logic [3:0]         div_cnt;
  logic               px_en;
  logic               armed;
  logic               step;
  logic [10:0]        hcnt;
  logic [10:0]        vcnt;
  logic [10:0]        bar_px;
  logic [2:0]         bar_idx;
  logic [1:0]         mode_q;
  logic [1:0]         mode_cur;
  logic               frame_first;
  logic               de;
  logic               chk_x;
  logic [2:0]         bar;
  logic [COLOR_W-1:0] grad;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  assign px_en = (div_cnt == DIV_LAST);

  // The first px_en after reset only seeds the counters; outputs trail them by one pixel.
  assign step = px_en & armed;

  always_ff @(posedge clk or negedge i_sclr_n) begin
    if (!i_sclr_n) begin
      div_cnt <= 4'd0;
      armed   <= 1'b0;
    end else begin
      div_cnt <= px_en ? 4'd0 : div_cnt + 4'd1;
      if (px_en) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_sclr_n) begin
    if (!i_sclr_n) begin
      hcnt    <= 11'd0;
      vcnt    <= 11'd0;
      bar_px  <= 11'd0;
      bar_idx <= 3'd0;
    end else if (step) begin
      if (hcnt == H_LAST) begin
        hcnt    <= 11'd0;
        bar_px  <= 11'd0;
        bar_idx <= 3'd0;
        vcnt    <= (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;
      end else begin
        hcnt <= hcnt + 11'd1;
        if (bar_px == BAR_LAST) begin
          bar_px  <= 11'd0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + 11'd1;
        end
      end
    end
  end

  assign frame_first = (hcnt == 11'd0) && (vcnt == 11'd0);
  assign mode_cur    = frame_first ? i_mode : mode_q;
  assign de          = (hcnt < H_VIS) && (vcnt < V_VIS);

`ifdef VGA_SCROLL_EN
  logic [10:0] frame_cnt;
  logic [10:0] offset;
  logic [10:0] sx;

  always_ff @(posedge clk or negedge i_sclr_n) begin
    if (!i_sclr_n) begin
      frame_cnt <= 11'd0;
    end else if (step && frame_first) begin
      frame_cnt <= frame_cnt + 11'd1;
    end
  end

  // The incremented count already applies to the first pixel of the new frame.
  assign offset = frame_first ? frame_cnt + 11'd1 : frame_cnt;
  assign sx     = hcnt + offset;
  assign chk_x  = sx[5];
  assign grad   = sx[COLOR_W+3:4];
  assign bar    = 3'(((32'(sx)) % H_ACTIVE) / BAR_W);
`else
  assign chk_x = hcnt[5];
  assign grad  = hcnt[COLOR_W+3:4];
  assign bar   = bar_idx;
`endif

  always_comb begin
    red   = '0;
    green = '0;
    blue  = '0;
    if (de) begin
      case (mode_cur)
        2'd0: begin
          red   = {COLOR_W{bar[2]}};
          green = {COLOR_W{bar[1]}};
          blue  = {COLOR_W{bar[0]}};
        end
        2'd1: begin
          if (chk_x ^ vcnt[5]) begin
            red   = FULL;
            green = FULL;
            blue  = FULL;
          end
        end
        2'd2: begin
          red   = grad;
          green = grad;
          blue  = grad;
        end
        default: begin
          red   = FULL;
          green = FULL;
          blue  = FULL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_sclr_n) begin
    if (!i_sclr_n) begin
      o_vga_red     <= '0;
      o_vga_green   <= '0;
      o_vga_blue    <= '0;
      o_vga_hsync   <= ~HS_ON;
      o_vga_vsync   <= ~VS_ON;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_x           <= 11'd0;
      o_y           <= 11'd0;
      mode_q        <= 2'd0;
    end else begin
      o_frame_start <= step & frame_first;
      if (step) begin
        o_vga_red   <= red;
        o_vga_green <= green;
        o_vga_blue  <= blue;
        o_vga_hsync <= (hcnt >= HS_BEG && hcnt < HS_END) ? HS_ON : ~HS_ON;
        o_vga_vsync <= (vcnt >= VS_BEG && vcnt < VS_END) ? VS_ON : ~VS_ON;
        o_de        <= de;
        o_x         <= de ? hcnt : 11'd0;
        o_y         <= de ? vcnt : 11'd0;
        if (frame_first) mode_q <= i_mode;
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter PX_DIV, default 4, clk cycles per pixel (range 1..16).
REQ-006 SHALL have parameters HSYNC_POL/VSYNC_POL, default 0, active sync level; parameter COLOR_W, default 4, bits per colour.
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port i_sclr_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port i_mode, input, 2, pattern select.
REQ-010 SHALL have ports o_vga_red/o_vga_green/o_vga_blue, output, COLOR_W each, pixel colour.
REQ-011 SHALL have ports o_vga_hsync/o_vga_vsync, output, 1 each, sync.
REQ-012 SHALL have ports o_de (display enable) and o_frame_start (pulse), output, 1 each; o_x/o_y, output, 11 each, current pixel coordinate.

Function
REQ-013 SHALL generate internal px_en: one-clk pulse every PX_DIV clks from a free-running divider counter; PX_DIV=1 gives px_en constantly high.
REQ-014 SHALL advance hcnt 0..H_TOTAL-1 (H_TOTAL = sum of horizontal parameters) on each px_en; at H_TOTAL-1 wrap to 0 and advance vcnt 0..V_TOTAL-1, wrapping to 0.
REQ-015 SHALL assert hsync (level HSYNC_POL) while H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on vcnt; inactive level otherwise.
REQ-016 SHALL assert o_de iff hcnt < H_ACTIVE and vcnt < V_ACTIVE; o_x/o_y = hcnt/vcnt when o_de, else 0.
REQ-017 SHALL register all outputs; each updates one clk after the px_en that sets the counters; all outputs mutually aligned.
REQ-018 SHALL pulse o_frame_start for exactly one clk when hcnt=0 and vcnt=0 are presented.
REQ-019 SHALL latch i_mode into a mode register only at frame start; mid-frame changes take effect next frame.
REQ-020 Mode 0: 8 vertical bars, width BAR_W = H_ACTIVE/8 tracked by a bar counter (no divider); bar index b gives red/green/blue full-scale iff b[2]/b[1]/b[0].
REQ-021 Mode 1: 32x32 checkerboard, white when x[5]^y[5]=1, else black; Mode 2: horizontal gradient, red = green = blue = x[COLOR_W+3:4]; Mode 3: solid white (all ones).
REQ-022 SHALL drive colours 0 whenever o_de is low.

Reset
REQ-023 SHALL, on i_sclr_n low, immediately clear divider, hcnt, vcnt, bar counter, mode register to 0; o_de, o_frame_start, colours, o_x, o_y to 0; syncs to inactive level.
REQ-024 SHALL, after release, present the first pixel (0,0) with o_frame_start high PX_DIV clks after the first px_en; reset mid-line restarts timing at (0,0).

Configuration
REQ-025 Macro VGA_SCROLL_EN defined: an 11-bit frame counter increments at each frame start and is added (mod 2^11) to x before pattern evaluation in modes 0-2, giving horizontal scroll of 1 pixel/frame; mode 0 bar index then derives from (x+offset) mod H_ACTIVE.
REQ-026 Macro VGA_SCROLL_EN undefined: no frame counter exists; patterns static.

Verification
REQ-027 Defaults, reset released -> hsync period 3200 clks, low width 384 clks; vsync period 1,680,000 clks, low width 6400 clks.
REQ-028 Defaults -> o_de high 2560 clks per active line, 480 active lines/frame; o_frame_start once per 1,680,000 clks.
REQ-029 i_mode=0 -> at x=0 colours 0/0/0; at x=80 blue=F, red=green=0; at x=560 red=green=blue=F.
REQ-030 i_mode changed 1->3 at line 200 -> checkerboard persists to frame end; solid white from next o_frame_start.
REQ-031 i_sclr_n pulsed low mid-line (x=300,y=100) -> outputs reset asynchronously same cycle; next frame_start 4 clks after first post-release px_en.
REQ-032 PX_DIV=1, HSYNC_POL=1 -> hsync high 96 clks per 800-clk line.
